// File: rtl/lz77_dec.sv
// lz77_dec: LZ77 token-to-byte decoder with a circular history window.
// Define LZ77_DEC_CHK_EN to compile in distance/length checking and the sticky err_o flag.
module lz77_dec #(
    parameter int DATA_WD = 8,
    parameter int LEN_WD  = 9,
    parameter int DST_WD  = 15,
    parameter int WIN_AW  = 10
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               start_i,
    output logic               done_o,
    input  logic               val_i,
    output logic               rdy_o,
    input  logic               flg_lit_i,
    input  logic [DATA_WD-1:0] dat_lit_i,
    input  logic [LEN_WD-1:0]  dat_len_i,
    input  logic [DST_WD-1:0]  dat_dst_i,
    input  logic               flg_lst_i,
    output logic               val_o,
    input  logic               rdy_i,
    output logic [DATA_WD-1:0] dat_o,
    output logic [15:0]        cnt_o,
    output logic               err_o
);
    typedef enum logic [1:0] {IDLE, RUN, CPY, LAST} st_t;
    st_t                st, st_n;
    logic [DATA_WD-1:0] hist [2**WIN_AW];
    logic [WIN_AW-1:0]  wp, ra;
    logic [LEN_WD-1:0]  rem;
    logic [DST_WD-1:0]  dst;
    logic [DATA_WD-1:0] b, wd;
    logic               lst, adv, acc, mat, we, zr;
    logic               unused_dst;

    assign adv = !val_o || rdy_i;
    assign acc = val_i && rdy_o;
    assign ra  = wp - dst[WIN_AW-1:0];
    assign b   = zr ? '0 : hist[ra];
    assign unused_dst = ^dst[DST_WD-1:WIN_AW];

    always_comb begin
        st_n  = st;
        rdy_o = 1'b0;
        we    = 1'b0;
        wd    = b;
        mat   = 1'b0;
        case (st)
            IDLE: st_n = start_i ? RUN : IDLE;
            RUN: begin
                rdy_o = adv;
                if (acc) begin
                    we   = flg_lit_i;
                    wd   = flg_lit_i ? dat_lit_i : b;
                    mat  = !flg_lit_i;
                    st_n = (flg_lit_i || dat_len_i == '0) ? (flg_lst_i ? LAST : RUN) : CPY;
                end
            end
            CPY: begin
                we = adv;
                if (adv && rem == LEN_WD'(1))
                    st_n = lst ? LAST : RUN;
            end
            // adv also releases a stream whose final token was a zero-length match
            LAST: st_n = adv ? IDLE : LAST;
            default: st_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (we)
            hist[wp] <= wd;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            st     <= IDLE;
            val_o  <= 1'b0;
            dat_o  <= '0;
            done_o <= 1'b0;
            cnt_o  <= '0;
            wp     <= '0;
            rem    <= '0;
            dst    <= '0;
            lst    <= 1'b0;
        end else begin
            st     <= st_n;
            done_o <= st == LAST && adv;
            if (we) begin
                dat_o <= wd;
                val_o <= 1'b1;
                wp    <= wp + 1'b1;
            end else if (adv) begin
                val_o <= 1'b0;
            end
            if (st == IDLE && start_i) begin
                cnt_o <= '0;
                wp    <= '0;
            end else if (val_o && rdy_i && cnt_o != '1) begin
                cnt_o <= cnt_o + 1'b1;
            end
            if (mat) begin
                rem <= dat_len_i;
                dst <= dat_dst_i;
                lst <= flg_lst_i;
            end else if (st == CPY && adv) begin
                rem <= rem - 1'b1;
            end
        end
    end

`ifdef LZ77_DEC_CHK_EN
    logic [WIN_AW:0] wcnt;
    logic            bad;

    assign bad = dat_dst_i == '0 || dat_dst_i > DST_WD'(wcnt);

    // wcnt saturates at the window depth: beyond that every distance up to 2^WIN_AW is valid
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wcnt  <= '0;
            zr    <= 1'b0;
            err_o <= 1'b0;
        end else begin
            if (st == IDLE && start_i) begin
                wcnt  <= '0;
                err_o <= 1'b0;
            end else if (we && !wcnt[WIN_AW]) begin
                wcnt <= wcnt + 1'b1;
            end
            if (mat) begin
                zr <= bad;
                if (bad || dat_len_i == '0)
                    err_o <= 1'b1;
            end
        end
    end
`else
    assign zr    = 1'b0;
    assign err_o = 1'b0;
`endif
endmodule

// File: tb/tb_lz77_dec.sv
// tb_lz77_dec: table-driven directed checks of lz77_dec plus a mid-copy reset sequence.
module tb_lz77_dec;
    typedef struct {
        logic       lit;
        logic [7:0] b;
        logic [8:0] len;
        logic [14:0] dst;
        logic       lst;
    } tok_t;
    typedef struct {
        int tok0;
        int ntok;
        int exp0;
        int nexp;
        int cyc;
        bit tog;
        bit err;
    } tst_t;

`ifdef LZ77_DEC_CHK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic        clk = 1'b0, rstn = 1'b0, start_i = 1'b0, val_i = 1'b0, rdy_i = 1'b1;
    logic        flg_lit_i = 1'b0, flg_lst_i = 1'b0;
    logic [7:0]  dat_lit_i = '0;
    logic [8:0]  dat_len_i = '0;
    logic [14:0] dat_dst_i = '0;
    logic        done_o, rdy_o, val_o, err_o;
    logic [7:0]  dat_o;
    logic [15:0] cnt_o;

    tok_t       toks [0:1099];
    logic [7:0] ex [0:1099];
    tst_t       tests [6];
    int         nt = 0, ne = 0, s_t = 0, s_e = 0;
    int         checks = 0, errors = 0;

    lz77_dec dut (
        .clk(clk), .rstn(rstn), .start_i(start_i), .done_o(done_o),
        .val_i(val_i), .rdy_o(rdy_o), .flg_lit_i(flg_lit_i), .dat_lit_i(dat_lit_i),
        .dat_len_i(dat_len_i), .dat_dst_i(dat_dst_i), .flg_lst_i(flg_lst_i),
        .val_o(val_o), .rdy_i(rdy_i), .dat_o(dat_o), .cnt_o(cnt_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, got, want);
        end
    endtask

    task automatic lit(input logic [7:0] v, input logic l);
        toks[nt] = '{1'b1, v, 9'd0, 15'd0, l};
        nt++;
    endtask

    task automatic mch(input logic [8:0] len, input logic [14:0] d, input logic l);
        toks[nt] = '{1'b0, 8'd0, len, d, l};
        nt++;
    endtask

    task automatic ex1(input logic [7:0] v);
        ex[ne] = v;
        ne++;
    endtask

    task automatic bt();
        s_t = nt;
        s_e = ne;
    endtask

    task automatic et(input int k, input int cyc, input bit tog, input bit err);
        tests[k] = '{s_t, nt - s_t, s_e, ne - s_e, cyc, tog, err};
    endtask

    task automatic drive(input tok_t t, input logic v);
        val_i     = v;
        flg_lit_i = t.lit;
        dat_lit_i = t.b;
        dat_len_i = t.len;
        dat_dst_i = t.dst;
        flg_lst_i = t.lst;
    endtask

    task automatic run(input int k);
        tst_t       t;
        int         ti, ei, dc;
        bit         pv, prdy;
        logic [7:0] pd;
        t  = tests[k];
        ti = 0;
        ei = 0;
        dc = -1;
        pv = 1'b0;
        prdy = 1'b1;
        pd = '0;
        start_i = 1'b1;
        rdy_i   = 1'b1;
        drive(toks[0], 1'b0);
        @(posedge clk); #1;
        for (int c = 1; c <= t.cyc + 50 && dc < 0; c++) begin
            rdy_i   = t.tog ? c[0] : 1'b1;
            start_i = (c == 4);
            drive(toks[t.tok0 + ti], ti < t.ntok);
            @(negedge clk);
            if (pv && !prdy)
                chk($sformatf("t%0d stall_hold", k), dat_o, pd);
            if (val_o && rdy_i) begin
                chk($sformatf("t%0d byte%0d", k, ei), dat_o, ei < t.nexp ? ex[t.exp0 + ei] : 8'hxx);
                ei++;
            end
            if (val_i && rdy_o)
                ti++;
            if (done_o)
                dc = c;
            pv = val_o;
            prdy = rdy_i;
            pd = dat_o;
            @(posedge clk); #1;
        end
        start_i = 1'b0;
        drive(toks[0], 1'b0);
        chk($sformatf("t%0d done_cycle", k), dc, t.cyc);
        chk($sformatf("t%0d nbytes", k), ei, t.nexp);
        chk($sformatf("t%0d cnt", k), cnt_o, t.nexp);
        chk($sformatf("t%0d err", k), err_o, t.err);
        @(negedge clk);
        chk($sformatf("t%0d done_single", k), done_o, 1'b0);
        @(posedge clk); #1;
    endtask

    initial begin
        bt(); lit(8'h41, 0); lit(8'h42, 0); lit(8'h43, 1);
        ex1(8'h41); ex1(8'h42); ex1(8'h43);
        et(0, 5, 0, 0);
        bt(); lit(8'h07, 0); mch(9'd5, 15'd1, 1);
        for (int i = 0; i < 6; i++) ex1(8'h07);
        et(1, 9, 0, 0);
        bt(); lit(8'h10, 0); lit(8'h20, 0); mch(9'd4, 15'd2, 1);
        for (int i = 0; i < 3; i++) begin ex1(8'h10); ex1(8'h20); end
        et(2, 14, 1, 0);
        bt(); lit(8'h55, 0); mch(9'd0, 15'd1, 0); lit(8'h66, 1);
        ex1(8'h55); ex1(8'h66);
        et(3, 5, 0, CHK);
        bt();
        for (int i = 0; i < 1030; i++) begin lit(8'(i), 0); ex1(8'(i)); end
        mch(9'd3, 15'd1024, 1);
        ex1(8'h06); ex1(8'h07); ex1(8'h08);
        et(4, 1036, 0, 0);
        bt(); lit(8'h01, 0); mch(9'd3, 15'd5, 1);
        ex1(8'h01);
        if (CHK) begin ex1(8'h00); ex1(8'h00); ex1(8'h00); end
        else begin ex1(8'hFC); ex1(8'hFD); ex1(8'hFE); end
        et(5, 7, 0, CHK);

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst rdy_o", rdy_o, 0);
        chk("rst val_o", val_o, 0);
        chk("rst dat_o", dat_o, 0);
        chk("rst done_o", done_o, 0);
        chk("rst cnt_o", cnt_o, 0);
        chk("rst err_o", err_o, 0);
        rstn = 1'b1;
        @(posedge clk); #1;

        for (int k = 0; k < 6; k++)
            run(k);

        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        drive('{1'b1, 8'h33, 9'd0, 15'd0, 1'b0}, 1'b1);
        @(posedge clk); #1;
        drive('{1'b0, 8'h00, 9'd258, 15'd1, 1'b1}, 1'b1);
        @(posedge clk); #1;
        drive(toks[0], 1'b0);
        repeat (6) @(posedge clk);
        #1;
        chk("mid val_o", val_o, 1);
        chk("mid dat_o", dat_o, 8'h33);
        chk("mid rdy_o", rdy_o, 0);
        rstn = 1'b0;
        #1;
        chk("arst rdy_o", rdy_o, 0);
        chk("arst val_o", val_o, 0);
        chk("arst dat_o", dat_o, 0);
        chk("arst done_o", done_o, 0);
        chk("arst cnt_o", cnt_o, 0);
        chk("arst err_o", err_o, 0);
        @(posedge clk); #2;
        rstn = 1'b1;
        @(negedge clk);
        chk("post done_o", done_o, 0);
        chk("post val_o", val_o, 0);
        @(posedge clk); #1;
        run(0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/lz77_dec.md
# lz77_dec

Token-to-byte LZ77 decoder: the receive-side counterpart of `lz77_top`. It consumes the literal/match token stream (`flg_lit`, `dat_lit`, `dat_len`, `dat_dst`, `flg_lst`) produced by the encoder and rebuilds the filtered scanline bytes from a circular history window. It is used in the loop-back check path (encoder → decoder → compare against `Filtered.dat`) and as the front end of a future PNG decode path.

## Interface
- `DATA_WD`, 8, byte width (`DATA_CHN_WD`).
- `LEN_WD`, 9, match length width (`SIZE_LEN_WD`). Legal lengths are 3..258.
- `DST_WD`, 15, match distance width (`SIZE_DST_WD`).
- `WIN_AW`, 10, history address width. Window depth = 2^WIN_AW bytes.

Ports:
- `clk` in 1: clock; the block has one clock domain.
- `rstn` in 1: asynchronous, active-low reset.
- `start_i` in 1: one-cycle pulse; begins a scanline.
- `done_o` out 1: one-cycle pulse; the last byte has been delivered.
- `val_i` in 1: token valid.
- `rdy_o` out 1: token ready. A token is accepted when `val_i && rdy_o`.
- `flg_lit_i` in 1: 1 = literal token, 0 = match token.
- `dat_lit_i` in DATA_WD: literal byte.
- `dat_len_i` in LEN_WD: match length.
- `dat_dst_i` in DST_WD: match distance (1 = previous byte).
- `flg_lst_i` in 1: last token of the scanline.
- `val_o` out 1: output byte valid.
- `rdy_i` in 1: downstream ready.
- `dat_o` out DATA_WD: decoded byte.
- `cnt_o` out 16: bytes delivered since `start_i`.
- `err_o` out 1: sticky error flag (see Configuration).

## Operation
- History is a 2^WIN_AW × DATA_WD register array. Read is asynchronous; write is synchronous. Write pointer `wp` wraps modulo 2^WIN_AW.
- Read address = `wp - dst`, modulo 2^WIN_AW.
- The output register advances when `adv = !val_o || rdy_i`.
- FSM states:
  - IDLE: `rdy_o = 0`. `start_i` → RUN and clears `cnt_o`, `wp` and `err_o`.
  - RUN: `rdy_o = adv`.
    - Literal accepted: `dat_o <= dat_lit_i`, `val_o <= 1`, `hist[wp] <= lit`, `wp++`. If `flg_lst_i` → LAST, else stay in RUN.
    - Match accepted: latch `rem = len`, `dst` and `lst`, then → CPY. No byte is emitted in this cycle; if `adv`, `val_o <= 0`.
  - CPY: `rdy_o = 0`. On each `adv`: `b = hist[wp-dst]`, `dat_o <= b`, `val_o <= 1`, `hist[wp] <= b`, `wp++`, `rem--`. When `rem == 1` on an `adv`: → LAST if `lst`, else → RUN.
  - LAST: wait until `val_o && rdy_i`, then pulse `done_o`, `val_o <= 0`, → IDLE.
- Overlapping copies (`dst < len`) are produced correctly. The asynchronous read returns the byte written at the previous edge, so `dst = 1` replicates one byte.
- `cnt_o` increments on every `val_o && rdy_i` and saturates at 16'hFFFF.
- `start_i` outside IDLE is ignored.
- The window persists across scanlines. `wp` resets only on `rstn` or `start_i`.
- `len = 0` is consumed as a no-op, and `err_o` is set when checks are compiled in.

## Timing
- Reset values: `rdy_o = 0`, `val_o = 0`, `dat_o = 0`, `done_o = 0`, `cnt_o = 0`, `err_o = 0`, state = IDLE, `wp = 0`.
- Asserting reset mid-operation drops any token or copy in progress immediately. No `done_o` is produced.
- Literal latency: accept edge → `val_o` high after the same edge, i.e. visible in the next cycle.
- Match latency: accept → first byte one cycle later, then one byte per cycle while `rdy_i = 1`.
- Throughput: a length-L match occupies L+1 cycles.
- `rdy_i` low holds `dat_o`/`val_o` stable and stalls the copy. `wp` and `rem` are frozen.
- `done_o` is asserted in the cycle after the final output handshake.

## Configuration
- `LZ77_DEC_CHK_EN` defined:
  - A match with `dst == 0`, or with `dst` greater than min(bytes written since `start_i`, 2^WIN_AW), sets `err_o`. Such a match still runs, emitting zeros in place of history.
  - `len == 0` sets `err_o`.
  - `err_o` stays set until `start_i` or reset.
- `LZ77_DEC_CHK_EN` undefined: no range tracking, `err_o` tied 0, and out-of-range distances read whatever the window holds.

## Test plan
- Literals: `start_i`, tokens lit 0x41, 0x42, 0x43 (last) with `rdy_i = 1` → `dat_o` 41,42,43 on consecutive cycles, `cnt_o = 3`, `done_o` pulses once.
- Overlap: lit 0x07, then match len 5 dst 1 (last) → 07×6, `rdy_o` low for 5 cycles, `done_o` after the 6th byte.
- Backpressure: lit 0x10, 0x20, match len 4 dst 2, with `rdy_i` toggling every cycle → 10,20,10,20,10,20 delivered in order. `dat_o` is stable while stalled.
- Wrap: with WIN_AW = 10, write 1030 literals (i & 0xFF), then match len 3 dst 1024 → bytes 06,07,08.
- Check: `LZ77_DEC_CHK_EN` on, `start_i`, lit 0x01, match len 3 dst 5 → `err_o = 1` and output 01,00,00,00. With the macro off, `err_o` stays 0.
- Reset: deassert `rstn` in the middle of a len-258 match → all outputs return to reset values at once. The next `start_i` decodes a fresh stream correctly.
